// File: rtl/heap_cmd_sched.sv
// heap_cmd_sched: buffers push/pop commands in a small FIFO, checks them against
// a shadow heap occupancy, and issues legal operations to the heap controller
// using a start/op/key/done handshake.
// Optional feature: define HEAP_CMD_TIMEOUT_EN to abort a WAIT that sees no done
// within TIMEOUT cycles (err_code 11).
module heap_cmd_sched #(
  parameter int unsigned KEY_W   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CAP     = 1024,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  output logic             start,
  output logic             op,
  output logic [KEY_W-1:0] key,
  input  logic             done,
  output logic [10:0]      occ,
  output logic             busy,
  output logic             rsp_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = 11;

  localparam logic [1:0] ERR_POP_EMPTY = 2'b01;
  localparam logic [1:0] ERR_PUSH_FULL = 2'b10;
`ifdef HEAP_CMD_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;
  localparam int unsigned TO_W = $clog2(TIMEOUT);
`endif

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("heap_cmd_sched: DEPTH must be a power of two >= 2");
  end
  if (CAP == 0 || CAP > 2047) begin : g_bad_cap
    $error("heap_cmd_sched: CAP must be in 1..2047 to fit occ");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("heap_cmd_sched: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;

  logic             mem_op  [DEPTH];
  logic [KEY_W-1:0] mem_key [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             head_op;
  logic [KEY_W-1:0] head_key;

`ifdef HEAP_CMD_TIMEOUT_EN
  logic [TO_W-1:0]  wait_cnt;
`endif

  assign fifo_wr  = cmd_valid && cmd_ready;
  // The sequencer consumes the head whenever it is idle, legal or not
  assign fifo_rd  = (state == IDLE) && (count != '0);
  assign head_op  = mem_op[rd_ptr];
  assign head_key = mem_key[rd_ptr];

  // FIFO occupancy after this cycle's write/read
  always_comb begin
    count_nxt = count;
    unique case ({fifo_wr, fifo_rd})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage (no reset needed; entries are only read once written)
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_op[wr_ptr]  <= cmd_op;
      mem_key[wr_ptr] <= cmd_key;
    end
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Sequencer: legality check, issue, wait for completion, shadow occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      start     <= 1'b0;
      op        <= 1'b0;
      key       <= '0;
      occ       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
`ifdef HEAP_CMD_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      start     <= 1'b0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_rd) begin
            if (head_op && (occ == '0)) begin
              err      <= 1'b1;
              err_code <= ERR_POP_EMPTY;
            end else if (!head_op && (occ == OCC_W'(CAP))) begin
              err      <= 1'b1;
              err_code <= ERR_PUSH_FULL;
            end else begin
              op    <= head_op;
              key   <= head_key;
              start <= 1'b1;
              busy  <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef HEAP_CMD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (done) begin
            occ       <= op ? (occ - OCC_W'(1)) : (occ + OCC_W'(1));
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef HEAP_CMD_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
